byte_stream_sync_fifo: RTL and testbench

//  Parametrised single-clock FWFT FIFO for the 250MHz book-side byte stream; buffers CDC output
//  (data + per-entry error tag) and adds downstream backpressure, which the CDC output lacks.

---
 rtl/stream_pkg.sv | 24 ++
 rtl/byte_stream_fifo_mem.sv | 34 +++
 rtl/byte_stream_sync_fifo.sv | 130 +++++++++++++
 tb/tb_byte_stream_sync_fifo.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Package : stream_pkg
// Brief   : Shared types and helpers for the book-side byte stream blocks.
// Rev     : 1.0  initial release
// ============================================================================
package stream_pkg;

  // Native payload width of the book-side byte stream.
  localparam int BYTE_W = 8;

  // One stream entry: payload byte plus its error tag, always kept together.
  typedef struct packed {
    logic              err;
    logic [BYTE_W-1:0] data;
  } byte_tag_t;

  // Pointer width for a power-of-two FIFO: address bits plus one wrap bit.
  function automatic int ptr_w(int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : stream_pkg
`default_nettype wire

// File: rtl/byte_stream_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module  : byte_stream_fifo_mem
// Brief   : 1-write / 1-read storage with synchronous write and asynchronous
//           read, intended to map onto distributed RAM. No reset on contents.
// Rev     : 1.0  initial release
// ============================================================================
module byte_stream_fifo_mem #(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clkIn,
  input  logic              wrEnIn,
  input  logic [ADDR_W-1:0] wrAddrIn,
  input  logic [WIDTH-1:0]  wrDataIn,
  input  logic [ADDR_W-1:0] rdAddrIn,
  output logic [WIDTH-1:0]  rdDataOut
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Store the incoming entry at the write address when enabled.
  always_ff @(posedge clkIn) begin
    if (wrEnIn) begin
      r_mem[wrAddrIn] <= wrDataIn;
    end
  end

  // Head entry is visible combinationally so the FIFO can present it FWFT.
  assign rdDataOut = r_mem[rdAddrIn];

endmodule : byte_stream_fifo_mem
`default_nettype wire

// File: rtl/byte_stream_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : byte_stream_sync_fifo
// Brief   : Single-clock first-word-fall-through FIFO for the book-side byte
//           stream. Stores payload plus error tag, adds downstream
//           backpressure, reports full / almost-full / sticky overflow /
//           occupancy, and supports a synchronous flush of a bad frame.
// Rev     : 1.0  initial release
// ============================================================================
module byte_stream_sync_fifo
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = BYTE_W,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 12
) (
  input  logic                    clkIn,
  input  logic                    rstIn,
  input  logic                    flushIn,
  input  logic                    wrEnIn,
  input  logic [DATA_WIDTH-1:0]   wrDataIn,
  input  logic                    wrErrIn,
  output logic                    fullOut,
  output logic                    almostFullOut,
  output logic                    overflowOut,
  input  logic                    rdReadyIn,
  output logic                    rdValidOut,
  output logic [DATA_WIDTH-1:0]   rdDataOut,
  output logic                    rdErrOut,
  output logic [ptr_w(DEPTH)-1:0] countOut
);

  localparam int c_ptrW   = ptr_w(DEPTH);
  localparam int c_addrW  = c_ptrW - 1;
  localparam int c_entryW = DATA_WIDTH + 1;
  localparam logic [c_ptrW-1:0] c_depthCnt = c_ptrW'(DEPTH);
  localparam logic [c_ptrW-1:0] c_afCnt    = c_ptrW'(AF_THRESH);

  // Reject unsupported geometries at elaboration time.
  generate
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_badDepth
      $error("byte_stream_sync_fifo: DEPTH must be a power of 2 and >= 4");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_badThresh
      $error("byte_stream_sync_fifo: AF_THRESH must be in 1..DEPTH");
    end
  endgenerate

  logic [c_ptrW-1:0]   r_wrPtr;
  logic [c_ptrW-1:0]   r_rdPtr;
  logic [c_ptrW-1:0]   r_count;
  logic                r_full;
  logic                r_almostFull;
  logic                r_overflow;
  logic                r_rdValid;

  logic                w_readFire;
  logic                w_writeAccept;
  logic                w_writeDrop;
  logic                w_memWrEn;
  logic [c_ptrW-1:0]   w_wrPtrNext;
  logic [c_ptrW-1:0]   w_rdPtrNext;
  logic [c_ptrW-1:0]   w_countNext;
  logic [c_entryW-1:0] w_rdEntry;

  // Handshake decode and next-state pointers; count derived from the
  // pointer difference so the wrap bit makes full vs empty unambiguous.
  always_comb begin
    w_readFire    = r_rdValid & rdReadyIn;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    w_writeAccept = wrEnIn & (~r_full | w_readFire);
    w_writeDrop   = wrEnIn & r_full & ~w_readFire;
    w_memWrEn     = w_writeAccept & ~flushIn;
    w_wrPtrNext   = r_wrPtr + c_ptrW'(w_writeAccept);
    w_rdPtrNext   = r_rdPtr + c_ptrW'(w_readFire);
    w_countNext   = w_wrPtrNext - w_rdPtrNext;
  end

  // Pointer, occupancy and flag registers; flush overrides any traffic.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_almostFull <= 1'b0;
      r_overflow   <= 1'b0;
      r_rdValid    <= 1'b0;
    end else if (flushIn) begin
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_almostFull <= 1'b0;
      r_overflow   <= 1'b0;
      r_rdValid    <= 1'b0;
    end else begin
      r_wrPtr      <= w_wrPtrNext;
      r_rdPtr      <= w_rdPtrNext;
      r_count      <= w_countNext;
      r_full       <= (w_countNext == c_depthCnt);
      r_almostFull <= (w_countNext >= c_afCnt);
      r_overflow   <= r_overflow | w_writeDrop;
      r_rdValid    <= (w_countNext != '0);
    end
  end

  byte_stream_fifo_mem #(
    .WIDTH  (c_entryW),
    .DEPTH  (DEPTH),
    .ADDR_W (c_addrW)
  ) u_mem (
    .clkIn     (clkIn),
    .wrEnIn    (w_memWrEn),
    .wrAddrIn  (r_wrPtr[c_addrW-1:0]),
    .wrDataIn  ({wrErrIn, wrDataIn}),
    .rdAddrIn  (r_rdPtr[c_addrW-1:0]),
    .rdDataOut (w_rdEntry)
  );

  assign rdDataOut     = w_rdEntry[DATA_WIDTH-1:0];
  assign rdErrOut      = w_rdEntry[DATA_WIDTH];
  assign rdValidOut    = r_rdValid;
  assign fullOut       = r_full;
  assign almostFullOut = r_almostFull;
  assign overflowOut   = r_overflow;
  assign countOut      = r_count;

endmodule : byte_stream_sync_fifo
`default_nettype wire

// File: tb/tb_byte_stream_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_byte_stream_sync_fifo
// Brief   : Self-checking bench for byte_stream_sync_fifo. A queue-based
//           reference model tracks contents, overflow and occupancy; directed
//           scenarios are followed by a randomized traffic phase.
// Rev     : 1.0  initial release
// ============================================================================
module tb_byte_stream_sync_fifo;
  import stream_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic          clkIn = 1'b0;
  logic          rstIn;
  logic          flushIn;
  logic          wrEnIn;
  logic [DW-1:0] wrDataIn;
  logic          wrErrIn;
  logic          fullOut;
  logic          almostFullOut;
  logic          overflowOut;
  logic          rdReadyIn;
  logic          rdValidOut;
  logic [DW-1:0] rdDataOut;
  logic          rdErrOut;
  logic [4:0]    countOut;

  byte_stream_sync_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF)
  ) dut (
    .clkIn         (clkIn),
    .rstIn         (rstIn),
    .flushIn       (flushIn),
    .wrEnIn        (wrEnIn),
    .wrDataIn      (wrDataIn),
    .wrErrIn       (wrErrIn),
    .fullOut       (fullOut),
    .almostFullOut (almostFullOut),
    .overflowOut   (overflowOut),
    .rdReadyIn     (rdReadyIn),
    .rdValidOut    (rdValidOut),
    .rdDataOut     (rdDataOut),
    .rdErrOut      (rdErrOut),
    .countOut      (countOut)
  );

  always #2 clkIn = ~clkIn;

  // Reference model state.
  byte_tag_t mQ[$];
  bit        mOvf;
  int        nTests;
  int        nFail;
  int        maxCount;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every DUT output against the model (called away from posedge).
  task automatic checkAll();
    int cnt;
    cnt = mQ.size();
    chk("valid", 32'(rdValidOut), 32'(cnt != 0));
    if (cnt != 0) begin
      chk("data", 32'(rdDataOut), 32'(mQ[0].data));
      chk("err", 32'(rdErrOut), 32'(mQ[0].err));
    end
    chk("count", 32'(countOut), 32'(cnt));
    chk("full", 32'(fullOut), 32'(cnt == DEPTH));
    chk("afull", 32'(almostFullOut), 32'(cnt >= AF));
    chk("ovf", 32'(overflowOut), 32'(mOvf));
    if (int'(countOut) > maxCount) maxCount = int'(countOut);
  endtask

  // Apply one cycle of stimulus at the negedge, advance the model, and check.
  task automatic step(input bit wr, input bit [7:0] d, input bit e, input bit rdy, input bit fl);
    bit fire;
    bit room;
    byte_tag_t ent;
    wrEnIn    = wr;
    wrDataIn  = d;
    wrErrIn   = e;
    rdReadyIn = rdy;
    flushIn   = fl;
    if (fl) begin
      mQ.delete();
      mOvf = 1'b0;
    end else begin
      fire = rdy && (mQ.size() != 0);
      room = (mQ.size() < DEPTH) || fire;
      if (fire) void'(mQ.pop_front());
      if (wr && room) begin
        ent.err  = e;
        ent.data = d;
        mQ.push_back(ent);
      end else if (wr) begin
        mOvf = 1'b1;
      end
    end
    @(posedge clkIn);
    @(negedge clkIn);
    checkAll();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (mQ.size() != 0 && guard < 64) begin
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      guard++;
    end
    chk("drain_empty", 32'(rdValidOut), 32'd0);
  endtask

  initial begin
    int written;
    bit rdy;
    nTests = 0; nFail = 0; mOvf = 1'b0; maxCount = 0;
    rstIn = 1'b1; flushIn = 1'b0; wrEnIn = 1'b0; wrDataIn = '0; wrErrIn = 1'b0; rdReadyIn = 1'b0;
    repeat (3) @(negedge clkIn);
    rstIn = 1'b0;
    checkAll();
    chk("rst_count", 32'(countOut), 32'd0);

    // 1: short stream with consumer always ready.
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    drain();
    chk("t1_count", 32'(countOut), 32'd0);

    // 2: fill with consumer stalled, overflow on the 17th write.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
      if (i == 10) chk("t2_af_11", 32'(almostFullOut), 32'd0);
      if (i == 11) chk("t2_af_12", 32'(almostFullOut), 32'd1);
    end
    chk("t2_full", 32'(fullOut), 32'd1);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("t2_ovf", 32'(overflowOut), 32'd1);
    chk("t2_cnt", 32'(countOut), 32'd16);
    drain();
    chk("t2_ovf_sticky", 32'(overflowOut), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // 3: write while full with a same-cycle read is accepted.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    chk("t3_cnt", 32'(countOut), 32'd16);
    chk("t3_ovf", 32'(overflowOut), 32'd0);
    drain();

    // 4: error tag travels with its byte.
    step(1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    chk("t4_err_head", 32'(rdErrOut), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("t4_data2", 32'(rdDataOut), 32'h11);
    chk("t4_err2", 32'(rdErrOut), 32'd0);
    drain();

    // 5: 40 bytes with alternating ready, across pointer wrap.
    written = 0;
    rdy = 1'b1;
    maxCount = 0;
    for (int c = 0; c < 200 && (written < 40 || mQ.size() != 0); c++) begin
      if (written < 40 && mQ.size() < DEPTH) begin
        step(1'b1, 8'(8'h30 + written), 1'(written % 2), rdy, 1'b0);
        written++;
      end else begin
        step(1'b0, 8'h00, 1'b0, rdy, 1'b0);
      end
      rdy = ~rdy;
    end
    chk("t5_written", 32'(written), 32'd40);
    chk("t5_ovf", 32'(overflowOut), 32'd0);
    chk("t5_max", 32'(maxCount <= DEPTH), 32'd1);

    // 6: flush with overflow set and a concurrent write, then async reset.
    for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("t6_cnt7", 32'(countOut), 32'd7);
    chk("t6_ovf", 32'(overflowOut), 32'd1);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    chk("t6_fl_cnt", 32'(countOut), 32'd0);
    chk("t6_fl_valid", 32'(rdValidOut), 32'd0);
    chk("t6_fl_ovf", 32'(overflowOut), 32'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    #1 rstIn = 1'b1;
    #0.5;
    chk("t6_rst_cnt", 32'(countOut), 32'd0);
    chk("t6_rst_valid", 32'(rdValidOut), 32'd0);
    chk("t6_rst_full", 32'(fullOut), 32'd0);
    chk("t6_rst_af", 32'(almostFullOut), 32'd0);
    chk("t6_rst_ovf", 32'(overflowOut), 32'd0);
    mQ.delete();
    mOvf = 1'b0;
    wrEnIn = 1'b0; flushIn = 1'b0;
    @(negedge clkIn);
    @(negedge clkIn);
    rstIn = 1'b0;
    checkAll();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom), ($urandom_range(0, 99) < 50),
           ($urandom_range(0, 199) == 0));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule : tb_byte_stream_sync_fifo
`default_nettype wire
